// File: rtl/wordop_pkg.sv
// Shared types and helpers for the word-widen/XOR lane schedulers.
package wordop_pkg;

    typedef logic [7:0]  word_t;
    typedef logic [15:0] dword_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_e;

    // Default value loaded into the key register at reset
    localparam dword_t KEY_RST_DEF = 16'h0001;

    // Zero-extend a byte to 16 bits and XOR with the key (no carries, no sign)
    function automatic dword_t widen_xor(input word_t w, input dword_t k);
        return {8'h00, w} ^ k;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after ptr, wrapping modulo NREQ. Grant is one-hot or zero.
module rr_arbiter #(
    parameter  int NREQ  = 4,
    localparam int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    // Scan NREQ positions starting at ptr; first hit wins
    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!grant_any && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wordop_rr_sched.sv
// Round-robin scheduler sharing one widen/XOR datapath among NREQ requesters.
// The result sits in a single output slot with a valid/ready handshake.
// Optional per-requester grant counters: define WORDOP_SCHED_STATS_EN.
module wordop_rr_sched
    import wordop_pkg::*;
#(
    parameter  int     NREQ    = 4,
    parameter  dword_t KEY_RST = KEY_RST_DEF,
    localparam int     IDX_W   = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*8-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    input  logic              cfg_we,
    input  logic [15:0]       cfg_key,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [IDX_W-1:0]  out_id,
    output logic              busy
`ifdef WORDOP_SCHED_STATS_EN
    ,
    input  logic              stats_clr,
    output logic [NREQ*16-1:0] grant_cnt
`endif
);

    slot_state_e      state_reg, state_next;
    logic [IDX_W-1:0] ptr_reg;
    dword_t           key_reg;
    dword_t           out_data_reg;
    logic [IDX_W-1:0] out_id_reg;

    logic             slot_free;
    logic [NREQ-1:0]  arb_req;
    logic [NREQ-1:0]  grant_vec;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_any;
    word_t            req_word [NREQ];

    // Unpack the flat request bus into per-requester bytes
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_word[gi] = req_data[8*gi +: 8];
    end

    // Slot can take a new word when empty or being drained this cycle;
    // requests are masked while reset is held so nothing is offered then
    assign slot_free = (state_reg == EMPTY) || out_ready;
    assign arb_req   = (slot_free && rst) ? req_valid : '0;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (arb_req),
        .ptr       (ptr_reg),
        .grant     (grant_vec),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign req_ready = grant_vec;
    assign busy      = out_valid || (|req_valid);
    assign out_data  = out_data_reg;
    assign out_id    = out_id_reg;

    // Output-slot state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next slot state: a grant refills the slot, a drain without grant empties it
    always_comb begin
        state_next = state_reg;
        if (grant_any) begin
            state_next = FULL;
        end else if (out_ready) begin
            state_next = EMPTY;
        end
    end

    // Slot occupancy drives the downstream valid
    always_comb begin
        out_valid = (state_reg == FULL);
    end

    // Result, tag and round-robin pointer update on each grant
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_reg <= '0;
            out_id_reg   <= '0;
            ptr_reg      <= '0;
        end else if (grant_any) begin
            out_data_reg <= widen_xor(req_word[grant_idx], key_reg);
            out_id_reg   <= grant_idx;
            ptr_reg      <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    // Key register; a same-cycle accept still sees the old key
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_reg <= KEY_RST;
        end else if (cfg_we) begin
            key_reg <= cfg_key;
        end
    end

`ifdef WORDOP_SCHED_STATS_EN
    logic [15:0] cnt_reg [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
        // Saturating grant counter; clear takes priority over increment
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                cnt_reg[gi] <= '0;
            end else if (stats_clr) begin
                cnt_reg[gi] <= '0;
            end else if (grant_vec[gi] && (cnt_reg[gi] != 16'hFFFF)) begin
                cnt_reg[gi] <= cnt_reg[gi] + 16'd1;
            end
        end
        assign grant_cnt[16*gi +: 16] = cnt_reg[gi];
    end
`endif

endmodule

// File: tb/tb_wordop_rr_sched.sv
// Self-checking bench for wordop_rr_sched: directed steps plus a randomized
// phase, compared against a small behavioural model of the output slot.
module tb_wordop_rr_sched;

    localparam int NREQ = 4;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              cfg_we;
    logic [15:0]       cfg_key;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic [IW-1:0]     out_id;
    logic              busy;
`ifdef WORDOP_SCHED_STATS_EN
    logic              stats_clr;
    logic [NREQ*16-1:0] grant_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int txn      = 0;

    // Reference model of the scheduler
    int          m_ptr;
    logic [15:0] m_key;
    logic        m_valid;
    logic [15:0] m_data;
    int          m_id;

    always #5 clk = ~clk;

    wordop_rr_sched #(.NREQ(NREQ), .KEY_RST(16'h0001)) dut (
        .clk       (clk),
        .rst       (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .cfg_we    (cfg_we),
        .cfg_key   (cfg_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
`ifdef WORDOP_SCHED_STATS_EN
        ,
        .stats_clr (stats_clr),
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Which requester the spec says gets the slot this cycle (-1 = none)
    function automatic int model_grant(input logic [NREQ-1:0] v, input logic ordy);
        if (m_valid && !ordy) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (v[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_ptr   = 0;
        m_key   = 16'h0001;
        m_valid = 1'b0;
        m_data  = 16'h0000;
        m_id    = 0;
    endfunction

    // One clock cycle: drive at negedge, check comb outputs, clock, check regs
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*8-1:0] d,
                        input logic ordy, input logic we, input logic [15:0] key);
        int g;
        logic [NREQ-1:0] exp_rdy;
        req_valid = v;
        req_data  = d;
        out_ready = ordy;
        cfg_we    = we;
        cfg_key   = key;
        #1;
        g = model_grant(v, ordy);
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("busy", 32'(busy), 32'(m_valid || (|v)));
        @(posedge clk);
        if (g >= 0) begin
            m_data  = {8'h00, d[8*g +: 8]} ^ m_key;
            m_id    = g;
            m_valid = 1'b1;
            m_ptr   = (g + 1) % NREQ;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        if (we) m_key = key;
        #1;
        check("out_valid", 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check("out_data", 32'(out_data), 32'(m_data));
            check("out_id", 32'(out_id), 32'(m_id));
        end
        txn++;
        $display("txn %0d: v=%b ordy=%b we=%b grant=%0d -> valid=%b id=%0d data=%h",
                 txn, v, ordy, we, g, out_valid, out_id, out_data);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        cfg_we    = 1'b0;
        cfg_key   = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_id", 32'(out_id), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] exp_d [5];
        int          exp_i [5];
`ifdef WORDOP_SCHED_STATS_EN
        stats_clr = 1'b0;
`endif
        do_reset();

        // Single word from requester 0
        step(4'b0001, 32'h0000_00A5, 1'b0, 1'b0, 16'h0);
        check("t1_data", 32'(out_data), 32'h00A4);
        check("t1_id", 32'(out_id), 32'd0);
        step(4'b0000, 32'h0, 1'b0, 1'b0, 16'h0);
        check("t1_busy_held", 32'(busy), 32'd1);
        step(4'b0000, 32'h0, 1'b1, 1'b0, 16'h0);
        check("t1_drained", 32'(out_valid), 32'd0);

        // Fairness with all requesters valid
        do_reset();
        exp_d = '{16'h0011, 16'h0021, 16'h0031, 16'h0041, 16'h0011};
        exp_i = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 32'h4030_2010, 1'b1, 1'b0, 16'h0);
            check("t2_id", 32'(out_id), 32'(exp_i[k]));
            check("t2_data", 32'(out_data), 32'(exp_d[k]));
        end

        // Stall with 16'h00FE pending (ptr now at 1)
        step(4'b0010, 32'h0000_FF00, 1'b1, 1'b0, 16'h0);
        check("t3_data", 32'(out_data), 32'h00FE);
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 32'h4433_2211, 1'b0, 1'b0, 16'h0);
            check("t3_hold_data", 32'(out_data), 32'h00FE);
            check("t3_hold_id", 32'(out_id), 32'd1);
        end
        step(4'b1111, 32'h4433_2211, 1'b1, 1'b0, 16'h0);
        check("t3_next_id", 32'(out_id), 32'd2);
        check("t3_next_data", 32'(out_data), 32'h0032);

        // Key change coincident with an accept
        do_reset();
        step(4'b0001, 32'h0000_000F, 1'b1, 1'b1, 16'hFF00);
        check("t4_old_key", 32'(out_data), 32'h000E);
        step(4'b0001, 32'h0000_000F, 1'b1, 1'b0, 16'h0);
        check("t4_new_key", 32'(out_data), 32'hFF0F);
        step(4'b0000, 32'h0, 1'b1, 1'b0, 16'h0);

        // Asynchronous reset while the slot is full
        step(4'b0100, 32'h00A5_0000, 1'b0, 1'b0, 16'h0);
        req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_async_valid", 32'(out_valid), 32'd0);
        check("t5_async_data", 32'(out_data), 32'd0);
        check("t5_async_ready", 32'(req_ready), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b1111, 32'h4433_2211, 1'b1, 1'b0, 16'h0);
        check("t5_first_id", 32'(out_id), 32'd0);
        check("t5_key_rst", 32'(out_data), 32'h0010);

        // Randomized traffic against the model
        for (int k = 0; k < 300; k++) begin
            step(NREQ'($urandom), $urandom, ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) == 0), 16'($urandom));
        end

`ifdef WORDOP_SCHED_STATS_EN
        // Grant counters: five grants to requester 2, then clear vs increment
        do_reset();
        for (int k = 0; k < 5; k++) begin
            step(4'b0100, 32'h0055_0000, 1'b1, 1'b0, 16'h0);
        end
        check("stats_cnt2", 32'(grant_cnt[47:32]), 32'd5);
        check("stats_cnt0", 32'(grant_cnt[15:0]), 32'd0);
        stats_clr = 1'b1;
        step(4'b0100, 32'h0055_0000, 1'b1, 1'b0, 16'h0);
        stats_clr = 1'b0;
        check("stats_clr_wins", 32'(grant_cnt[47:32]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
